// File: rtl/hilo_div_sequencer.sv
// Purpose : sequences the iterative divider (load/step/fix) and guards HILO against hazards in EX.
// Latency : accept at T -> div_step T+1..T+DIV_CYCLES, div_fix T+DIV_CYCLES+1 (signed only), hilo_we next.
// Backpr. : never stalls itself once a divide is accepted; requests muldiv_stall for any HILO user while busy.
//
// Ports
//   clock, reset              core clock (rising edge), async active-low reset
//   ex_div_req/_signed        DIV/DIVU present in EX, 1 = signed
//   ex_divisor_zero           divisor operand is zero (divide is dropped, HILO left alone)
//   ex_hilo_access            non-divide HILO reader/writer in EX
//   ex_stall, ex_flush        EX held / killed by another source; only gate the accept
//   div_load                  combinational operand load strobe
//   div_step, div_fix         registered divider controls
//   div_signed                operation type captured at accept
//   hilo_we                   registered HILO commit strobe
//   div_busy                  sequencer not idle
//   muldiv_stall              combinational stall request to the pipeline
module hilo_div_sequencer #(
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic clock,
  input  logic reset,
  input  logic ex_div_req,
  input  logic ex_div_signed,
  input  logic ex_divisor_zero,
  input  logic ex_hilo_access,
  input  logic ex_stall,
  input  logic ex_flush,
  output logic div_load,
  output logic div_step,
  output logic div_fix,
  output logic div_signed,
  output logic hilo_we,
  output logic div_busy,
  output logic muldiv_stall
);

  // One-hot style encoding: every registered control output is a single
  // state flop, so they come straight off a register with no decode glitches.
  typedef enum logic [2:0] {
    S_IDLE   = 3'b000,
    S_ITER   = 3'b001,
    S_FIX    = 3'b010,
    S_COMMIT = 3'b100
  } state_t;

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DIV_CYCLES - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic             r_div_signed;
  logic             w_accept;

  // ex_stall/ex_flush only gate the accept; they never feed muldiv_stall,
  // which keeps the pipeline stall network free of combinational loops.
  assign w_accept = (r_state == S_IDLE) & ex_div_req & ~ex_stall & ~ex_flush;

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    case (r_state)
      S_IDLE: begin
        // A zero divisor is accepted (operands loaded) but never iterated,
        // so HILO keeps its old value.
        if (w_accept && !ex_divisor_zero) begin
          w_state_nxt = S_ITER;
          w_count_nxt = LP_LAST;
        end
      end
      S_ITER: begin
        w_count_nxt = r_count - 1'b1;
        if (r_count == '0) begin
          w_count_nxt = '0;
          w_state_nxt = r_div_signed ? S_FIX : S_COMMIT;
        end
      end
      S_FIX:    w_state_nxt = S_COMMIT;
      S_COMMIT: w_state_nxt = S_IDLE;
      default: begin
        w_state_nxt = S_IDLE;
        w_count_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_count      <= '0;
      r_div_signed <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      if (w_accept) begin
        r_div_signed <= ex_div_signed;
      end
    end
  end

  assign div_load   = w_accept;
  assign div_step   = r_state[0];
  assign div_fix    = r_state[1];
  assign hilo_we    = r_state[2];
  assign div_signed = r_div_signed;
  assign div_busy   = (r_state != S_IDLE);

  // Holds through COMMIT so the waiting op sees the committed HILO in the
  // first IDLE cycle; also blocks a second divide until then.
  assign muldiv_stall = div_busy & (ex_div_req | ex_hilo_access);

endmodule

// File: tb/tb_hilo_div_sequencer.sv
// Scoreboard bench: each accepted divide pushes its expected commit timing,
// the monitor pops and checks it when hilo_we appears.
module tb_hilo_div_sequencer;

  logic clock;
  logic reset;
  logic ex_div_req;
  logic ex_div_signed;
  logic ex_divisor_zero;
  logic ex_hilo_access;
  logic ex_stall;
  logic ex_flush;
  logic div_load;
  logic div_step;
  logic div_fix;
  logic div_signed;
  logic hilo_we;
  logic div_busy;
  logic muldiv_stall;

  hilo_div_sequencer #(.DIV_CYCLES(32), .CNT_W(6)) dut (
    .clock           (clock),
    .reset           (reset),
    .ex_div_req      (ex_div_req),
    .ex_div_signed   (ex_div_signed),
    .ex_divisor_zero (ex_divisor_zero),
    .ex_hilo_access  (ex_hilo_access),
    .ex_stall        (ex_stall),
    .ex_flush        (ex_flush),
    .div_load        (div_load),
    .div_step        (div_step),
    .div_fix         (div_fix),
    .div_signed      (div_signed),
    .hilo_we         (hilo_we),
    .div_busy        (div_busy),
    .muldiv_stall    (muldiv_stall)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  typedef struct {
    int we_cyc;
    int fix_cyc;
    int sgn;
  } exp_t;

  exp_t q[$];
  int   step_cnt = 0;
  int   fix_cyc  = -1;

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clock) begin
    if (!reset) begin
      step_cnt = 0;
      fix_cyc  = -1;
    end else begin
      if (div_step) begin
        chk("step_without_div", int'(q.size() > 0), 1);
        step_cnt++;
      end
      if (div_fix) fix_cyc = cyc;
      if (hilo_we) begin
        if (q.size() == 0) begin
          chk("hilo_we_unexpected", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("we_cycle", cyc, e.we_cyc);
          chk("step_count", step_cnt, 32);
          chk("fix_cycle", fix_cyc, e.fix_cyc);
          chk("we_signed", int'(div_signed), e.sgn);
        end
        step_cnt = 0;
        fix_cyc  = -1;
      end
    end
  end

  // Present one divide for a single cycle; returns the accept cycle.
  task automatic do_div(input bit sgn, input bit zero, output int t);
    @(posedge clock); #1;
    ex_div_req = 1'b1; ex_div_signed = sgn; ex_divisor_zero = zero;
    @(negedge clock);
    chk("div_load", int'(div_load), 1);
    t = cyc;
    if (!zero) q.push_back('{we_cyc: t + 33 + int'(sgn), fix_cyc: sgn ? t + 33 : -1, sgn: int'(sgn)});
    @(posedge clock); #1;
    ex_div_req = 1'b0; ex_div_signed = 1'b0; ex_divisor_zero = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (!div_busy && q.size() == 0) break;
    end
    chk("idle_busy", int'(div_busy), 0);
    chk("idle_queue", q.size(), 0);
  endtask

  // Present a divide blocked by flush or stall; it must not be accepted.
  task automatic blocked_req(input bit fl, input bit st, input string tag);
    @(posedge clock); #1;
    ex_div_req = 1'b1; ex_div_signed = 1'b1; ex_flush = fl; ex_stall = st;
    @(negedge clock);
    chk({tag, "_load"}, int'(div_load), 0);
    @(posedge clock); #1;
    ex_div_req = 1'b0; ex_flush = 1'b0; ex_stall = 1'b0;
    @(negedge clock);
    chk({tag, "_busy"}, int'(div_busy), 0);
  endtask

  initial begin
    int t;
    reset = 1'b0;
    ex_div_req = 1'b0; ex_div_signed = 1'b0; ex_divisor_zero = 1'b0;
    ex_hilo_access = 1'b0; ex_stall = 1'b0; ex_flush = 1'b0;

    // Reset values
    #12;
    chk("rst_step", int'(div_step), 0);
    chk("rst_fix", int'(div_fix), 0);
    chk("rst_we", int'(hilo_we), 0);
    chk("rst_busy", int'(div_busy), 0);
    chk("rst_signed", int'(div_signed), 0);
    chk("rst_load", int'(div_load), 0);
    chk("rst_stall", int'(muldiv_stall), 0);
    @(negedge clock); #2 reset = 1'b1;

    // DIVU, non-zero divisor
    do_div(1'b0, 1'b0, t);
    @(negedge clock);
    chk("divu_signed", int'(div_signed), 0);
    wait_idle();

    // DIV, non-zero divisor; ex_stall/ex_flush must not mask the hazard stall
    do_div(1'b1, 1'b0, t);
    ex_div_req = 1'b1; ex_flush = 1'b1; ex_stall = 1'b1;
    @(negedge clock);
    chk("div_signed_held", int'(div_signed), 1);
    chk("busy_stall_indep", int'(muldiv_stall), 1);
    chk("busy_no_load", int'(div_load), 0);
    @(posedge clock); #1;
    ex_div_req = 1'b0; ex_flush = 1'b0; ex_stall = 1'b0;
    wait_idle();
    chk("div_signed_after", int'(div_signed), 1);

    // MFLO behind a DIVU
    do_div(1'b0, 1'b0, t);
    while (cyc < t + 5) begin @(posedge clock); #1; end
    ex_hilo_access = 1'b1;
    for (int k = t + 5; k <= t + 34; k++) begin
      @(negedge clock);
      chk("mflo_stall", int'(muldiv_stall), int'(k <= t + 33));
      if (k == t + 34) chk("mflo_idle", int'(div_busy), 0);
      @(posedge clock); #1;
    end
    ex_hilo_access = 1'b0;
    wait_idle();

    // Divide by zero: load pulse only, captures div_signed
    do_div(1'b0, 1'b1, t);
    @(negedge clock);
    chk("dz_busy", int'(div_busy), 0);
    chk("dz_signed", int'(div_signed), 0);
    repeat (40) @(negedge clock);
    chk("dz_busy_late", int'(div_busy), 0);

    // Flush / stall suppress accept, then a clean request is accepted
    blocked_req(1'b1, 1'b0, "flush");
    blocked_req(1'b0, 1'b1, "stall");
    blocked_req(1'b1, 1'b1, "flush_stall");
    do_div(1'b1, 1'b0, t);
    wait_idle();

    // Reset mid-DIV
    do_div(1'b1, 1'b0, t);
    while (cyc < t + 10) begin @(posedge clock); #1; end
    #2 reset = 1'b0;
    #1;
    chk("arst_step", int'(div_step), 0);
    chk("arst_busy", int'(div_busy), 0);
    chk("arst_fix", int'(div_fix), 0);
    chk("arst_we", int'(hilo_we), 0);
    chk("arst_signed", int'(div_signed), 0);
    q.delete();
    repeat (2) @(negedge clock);
    #2 reset = 1'b1;
    repeat (40) @(negedge clock);
    chk("arst_quiet", int'(div_busy), 0);
    do_div(1'b1, 1'b0, t);
    wait_idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation timed out at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
